cpu_axi_mem_bridge: RTL and testbench
=====================================

Name: cpu_axi_mem_bridge

Overview:
- Parametrised successor to the core's fixed single-cycle SRAM-style memory port (cs/oe/web/address/di/do).
- Accepts one CPU-side request (instruction or data port), issues a single-beat AXI4 transaction and stalls the pipeline until it completes.
- Two instances, one per CPU port, sit between the cpu core and the AXI interconnect.
- Adds wait-state tolerance, base-address relocation, response capture and error reporting; the fixed port has none of these.

Parameters:
- DATA_W, 32, data bus width; must be 32 or 64.
- WADDR_W, 14, CPU word-address width.
- ADDR_W, 32, AXI byte-address width.
- ID_W, 4, AXI ID width.
- MASTER_ID, 0, value driven on ARID/AWID.
- BASE_ADDR, 0, byte offset added to every translated address.
- TIMEOUT_CYC, 1023, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- cpu_cs, in, 1, request chip select.
- cpu_oe, in, 1, read enable.
- cpu_web, in, DATA_W/8, active-low byte write enables.
- cpu_addr, in, WADDR_W, word address.
- cpu_di, in, DATA_W, write data.
- cpu_do, out, DATA_W, read data.
- cpu_stall, out, 1, freeze pipeline.
- cpu_err, out, 1, one-cycle pulse on SLVERR/DECERR/timeout.
- ARID, out, ID_W.
- ARADDR, out, ADDR_W.
- ARLEN, out, 8; ARSIZE, out, 3; ARBURST, out, 2.
- ARVALID, out, 1; ARREADY, in, 1.
- RID, in, ID_W; RDATA, in, DATA_W; RRESP, in, 2; RLAST, in, 1; RVALID, in, 1; RREADY, out, 1.
- AWID, out, ID_W; AWADDR, out, ADDR_W; AWLEN, out, 8; AWSIZE, out, 3; AWBURST, out, 2; AWVALID, out, 1; AWREADY, in, 1.
- WDATA, out, DATA_W; WSTRB, out, DATA_W/8; WLAST, out, 1; WVALID, out, 1; WREADY, in, 1.
- BID, in, ID_W; BRESP, in, 2; BVALID, in, 1; BREADY, out, 1.

Behaviour:
- One clock; reset synchronous, active-high.
- Reset values: state=IDLE; all VALID/READY outputs 0; cpu_do=0; cpu_err=0; captured addr/data/strb=0.
- Request decode, sampled in IDLE:
  - write when cpu_cs & (cpu_web != all-ones);
  - else read when cpu_cs & cpu_oe;
  - else no request. A write takes precedence over a simultaneous oe.
- Address translation: byte address = BASE_ADDR + (cpu_addr << log2(DATA_W/8)), truncated to ADDR_W (wraps modulo 2^ADDR_W).
- Fixed fields: ARLEN=AWLEN=0; ARSIZE=AWSIZE=log2(DATA_W/8); ARBURST=AWBURST=INCR (2'b01); WLAST=1; WSTRB=~cpu_web, captured.
- States:
  - IDLE: on a request, capture addr/data/strb. A read goes to AR with ARVALID=1. A write goes to AW_W with AWVALID=WVALID=1.
  - AR: hold ARVALID and ARADDR stable until ARREADY; then ARVALID=0, go to R.
  - R: RREADY=1. On RVALID, capture RDATA into cpu_do, go to DONE; RRESP[1]=1 pulses cpu_err in DONE.
  - AW_W: AWVALID and WVALID drop independently on their own ready. When both have handshaken (same or different cycles), go to B.
  - B: BREADY=1. On BVALID go to DONE; BRESP[1]=1 pulses cpu_err.
  - DONE: exactly one cycle; cpu_stall=0; then IDLE.
- cpu_stall is combinational: 1 when (IDLE & request) or state in {AR, R, AW_W, B}; 0 in DONE and in IDLE with no request. Minimum latency, read or write, is 3 stall cycles with zero-wait slave (IDLE→AR/AW_W→R/B→DONE).
- cpu_do holds its last read value until the next read completes. Writes leave cpu_do unchanged.
- RID/BID mismatch with MASTER_ID is ignored (single outstanding transaction).
- Reset mid-transaction aborts immediately to IDLE with all valids low. The interconnect must be reset together.
- VALID, once asserted, never drops before its ready (AXI rule).

Optional Feature:
- Macro: AXI_BRIDGE_TIMEOUT_EN.
- With it: a counter clears on entering AR/AW_W and increments each cycle in AR/R/AW_W/B. Reaching TIMEOUT_CYC forces DONE, drops all valids/readies, pulses cpu_err, and sets cpu_do=0 for reads.
- Without it: no counter; the bridge waits indefinitely.

Test Plan:
- Zero-wait read: cpu_addr=14'h0004, oe=1, BASE_ADDR=0, RDATA=32'hDEADBEEF → ARADDR=32'h10, stall high 3 cycles, cpu_do=DEADBEEF in DONE, cpu_err=0.
- Byte write: cpu_web=4'b1101, cpu_di=32'h0000AB00 → WSTRB=4'b0010, WDATA=0000AB00. AWREADY delayed 2 cycles and WREADY 0 cycles; AWVALID stays high until accepted, WVALID drops after 1 cycle, B completes, stall then releases.
- Wait states: ARREADY low 5 cycles, RVALID 4 cycles later → ARADDR stable throughout, stall=1 for 11 cycles, single DONE cycle.
- Error response: BRESP=2'b10 → cpu_err pulses exactly 1 cycle in DONE. A read with RRESP=2'b11 → cpu_err pulse, and cpu_do takes RDATA.
- Reset mid-read: rst asserted in R state → next cycle IDLE, ARVALID=RREADY=0, cpu_do=0, cpu_stall=0 with no request.
- AXI_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=8: slave never asserts ARREADY → DONE after 8 cycles, cpu_err=1, cpu_do=0, ARVALID=0.

Source files
------------

// File: rtl/cpu_axi_mem_bridge_if.sv
// cpu_axi_mem_bridge_if: single-beat AXI4 bundle between cpu_axi_mem_bridge and the interconnect
interface cpu_axi_mem_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [7:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;
    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [7:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;
    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/cpu_axi_mem_bridge.sv
// cpu_axi_mem_bridge: CPU SRAM-style port to single-beat AXI4 master; AXI_BRIDGE_TIMEOUT_EN adds a watchdog
module cpu_axi_mem_bridge #(
    parameter int                DATA_W      = 32,
    parameter int                WADDR_W     = 14,
    parameter int                ADDR_W      = 32,
    parameter int                ID_W        = 4,
    parameter logic [ID_W-1:0]   MASTER_ID   = '0,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                TIMEOUT_CYC = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_cs,
    input  logic                cpu_oe,
    input  logic [DATA_W/8-1:0] cpu_web,
    input  logic [WADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]   cpu_di,
    output logic [DATA_W-1:0]   cpu_do,
    output logic                cpu_stall,
    output logic                cpu_err,
    cpu_axi_mem_bridge_if.master axi
);
    localparam int SB = DATA_W / 8;
    localparam int SZ = $clog2(SB);
    localparam logic [2:0] IDLE = 3'd0, AR = 3'd1, R = 3'd2, AW_W = 3'd3, B = 3'd4, DONE = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] byte_addr;
    logic [DATA_W-1:0] data_q;
    logic [SB-1:0]     strb_q;
    logic              wr_req;
    logic              rd_req;
    logic              busy;
    logic              tmo;
    logic              aw_ok;
    logic              w_ok;
    logic              unused_ok;

    assign wr_req    = cpu_cs && (cpu_web != '1);
    assign rd_req    = cpu_cs && cpu_oe && !wr_req;
    assign busy      = state inside {AR, R, AW_W, B};
    assign cpu_stall = busy || (state == IDLE && (wr_req || rd_req));
    assign byte_addr = BASE_ADDR + (ADDR_W'(cpu_addr) << SZ);
    // each write channel completes on its own; B waits until both are done
    assign aw_ok     = !axi.AWVALID || axi.AWREADY;
    assign w_ok      = !axi.WVALID || axi.WREADY;

    assign axi.ARID    = MASTER_ID;
    assign axi.ARADDR  = addr_q;
    assign axi.ARLEN   = 8'd0;
    assign axi.ARSIZE  = 3'(SZ);
    assign axi.ARBURST = 2'b01;
    assign axi.RREADY  = state == R;
    assign axi.AWID    = MASTER_ID;
    assign axi.AWADDR  = addr_q;
    assign axi.AWLEN   = 8'd0;
    assign axi.AWSIZE  = 3'(SZ);
    assign axi.AWBURST = 2'b01;
    assign axi.WDATA   = data_q;
    assign axi.WSTRB   = strb_q;
    assign axi.WLAST   = 1'b1;
    assign axi.BREADY  = state == B;

`ifdef AXI_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    assign tmo       = busy && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign unused_ok = ^{axi.RID, axi.BID, axi.RLAST, axi.RRESP[0], axi.BRESP[0]};
    always_ff @(posedge clk) begin
        if (rst || !busy)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end
`else
    assign tmo       = 1'b0;
    assign unused_ok = ^{axi.RID, axi.BID, axi.RLAST, axi.RRESP[0], axi.BRESP[0], 32'(TIMEOUT_CYC)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            axi.ARVALID <= 1'b0;
            axi.AWVALID <= 1'b0;
            axi.WVALID  <= 1'b0;
            cpu_do      <= '0;
            cpu_err     <= 1'b0;
        end else begin
            cpu_err <= 1'b0;
            if (tmo) begin
                state       <= DONE;
                axi.ARVALID <= 1'b0;
                axi.AWVALID <= 1'b0;
                axi.WVALID  <= 1'b0;
                cpu_err     <= 1'b1;
                if (state == AR || state == R)
                    cpu_do <= '0;
            end else begin
                case (state)
                    IDLE: if (wr_req || rd_req) begin
                        addr_q      <= byte_addr;
                        data_q      <= cpu_di;
                        strb_q      <= ~cpu_web;
                        state       <= wr_req ? AW_W : AR;
                        axi.ARVALID <= rd_req;
                        axi.AWVALID <= wr_req;
                        axi.WVALID  <= wr_req;
                    end
                    AR: if (axi.ARREADY) begin
                        axi.ARVALID <= 1'b0;
                        state       <= R;
                    end
                    R: if (axi.RVALID) begin
                        cpu_do  <= axi.RDATA;
                        cpu_err <= axi.RRESP[1];
                        state   <= DONE;
                    end
                    AW_W: begin
                        axi.AWVALID <= axi.AWVALID && !axi.AWREADY;
                        axi.WVALID  <= axi.WVALID && !axi.WREADY;
                        if (aw_ok && w_ok)
                            state <= B;
                    end
                    B: if (axi.BVALID) begin
                        cpu_err <= axi.BRESP[1];
                        state   <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cpu_axi_mem_bridge.sv
// tb_cpu_axi_mem_bridge: directed checks of cpu_axi_mem_bridge with a scripted single-beat AXI slave
module tb_cpu_axi_mem_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_cs = 1'b0;
    logic        cpu_oe = 1'b0;
    logic [3:0]  cpu_web = 4'hF;
    logic [13:0] cpu_addr = '0;
    logic [31:0] cpu_di = '0;
    logic [31:0] cpu_do;
    logic        cpu_stall;
    logic        cpu_err;

    int n_cmp = 0;
    int n_bad = 0;
    int stalls, errs, ar_n, r_n, aw_n, w_n, b_n;
    logic        stable, done_err, after_err, after_stall, seen;
    logic [31:0] addr_q, done_do, wdata_q;
    logic [3:0]  wstrb_q;

    cpu_axi_mem_bridge_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) axi ();

    cpu_axi_mem_bridge dut (
        .clk(clk), .rst(rst), .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_web(cpu_web),
        .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_stall(cpu_stall),
        .cpu_err(cpu_err), .axi(axi)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one request to completion; the slave raises each ready/valid after the given number of waiting cycles.
    task automatic run_txn(input logic [13:0] a, input logic oe, input logic [3:0] web, input logic [31:0] di,
                           input int ar_wait, input int r_wait, input int aw_wait, input int w_wait,
                           input int b_wait, input logic [31:0] rdata, input logic [1:0] resp);
        stalls = 0; errs = 0; ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0;
        stable = 1'b1; seen = 1'b0; done_do = 'x; done_err = 1'bx; addr_q = 'x;
        cpu_cs = 1'b1; cpu_oe = oe; cpu_web = web; cpu_addr = a; cpu_di = di;
        for (int c = 0; c < 100 && !seen; c++) begin
            axi.ARREADY = axi.ARVALID && ar_n >= ar_wait;
            axi.RVALID  = axi.RREADY && r_n >= r_wait;
            axi.AWREADY = axi.AWVALID && aw_n >= aw_wait;
            axi.WREADY  = axi.WVALID && w_n >= w_wait;
            axi.BVALID  = axi.BREADY && b_n >= b_wait;
            axi.RDATA = rdata; axi.RRESP = resp; axi.BRESP = resp;
            #1;
            if (axi.ARVALID) begin
                if (ar_n == 0) addr_q = axi.ARADDR; else if (axi.ARADDR !== addr_q) stable = 1'b0;
                ar_n++;
            end
            if (axi.AWVALID) begin
                if (aw_n == 0) addr_q = axi.AWADDR; else if (axi.AWADDR !== addr_q) stable = 1'b0;
                aw_n++;
            end
            if (axi.WVALID) begin
                wstrb_q = axi.WSTRB; wdata_q = axi.WDATA; w_n++;
            end
            if (axi.RREADY) r_n++;
            if (axi.BREADY) b_n++;
            if (cpu_err) errs++;
            if (cpu_stall) stalls++;
            else begin
                seen = 1'b1; done_do = cpu_do; done_err = cpu_err;
            end
            step();
        end
        cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_web = 4'hF;
        axi.ARREADY = 0; axi.RVALID = 0; axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0;
        #1;
        after_err = cpu_err; after_stall = cpu_stall;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_cmp++; if (axi.ARVALID !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid got %b want 0", axi.ARVALID); end
        n_cmp++; if (axi.AWVALID !== 1'b0) begin n_bad++; $display("FAIL rst_awvalid got %b want 0", axi.AWVALID); end
        n_cmp++; if (axi.WVALID !== 1'b0) begin n_bad++; $display("FAIL rst_wvalid got %b want 0", axi.WVALID); end
        n_cmp++; if (axi.RREADY !== 1'b0) begin n_bad++; $display("FAIL rst_rready got %b want 0", axi.RREADY); end
        n_cmp++; if (axi.BREADY !== 1'b0) begin n_bad++; $display("FAIL rst_bready got %b want 0", axi.BREADY); end
        n_cmp++; if (cpu_do !== 32'h0) begin n_bad++; $display("FAIL rst_cpu_do got %h want 0", cpu_do); end
        n_cmp++; if (cpu_err !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_err got %b want 0", cpu_err); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", cpu_stall); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fields();
        n_cmp++; if (axi.ARLEN !== 8'd0) begin n_bad++; $display("FAIL arlen got %h want 0", axi.ARLEN); end
        n_cmp++; if (axi.ARSIZE !== 3'd2) begin n_bad++; $display("FAIL arsize got %h want 2", axi.ARSIZE); end
        n_cmp++; if (axi.ARBURST !== 2'b01) begin n_bad++; $display("FAIL arburst got %b want 01", axi.ARBURST); end
        n_cmp++; if (axi.AWLEN !== 8'd0) begin n_bad++; $display("FAIL awlen got %h want 0", axi.AWLEN); end
        n_cmp++; if (axi.AWSIZE !== 3'd2) begin n_bad++; $display("FAIL awsize got %h want 2", axi.AWSIZE); end
        n_cmp++; if (axi.AWBURST !== 2'b01) begin n_bad++; $display("FAIL awburst got %b want 01", axi.AWBURST); end
        n_cmp++; if (axi.WLAST !== 1'b1) begin n_bad++; $display("FAIL wlast got %b want 1", axi.WLAST); end
        n_cmp++; if (axi.ARID !== 4'd0) begin n_bad++; $display("FAIL arid got %h want 0", axi.ARID); end
    endtask

    task automatic test_no_request();
        cpu_cs = 1'b1; cpu_oe = 1'b0; cpu_web = 4'hF;
        #1;
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL noreq_stall got %b want 0", cpu_stall); end
        step(); step();
        n_cmp++; if ({axi.ARVALID, axi.AWVALID, axi.WVALID} !== 3'b000) begin n_bad++; $display("FAIL noreq_valids got %b want 000", {axi.ARVALID, axi.AWVALID, axi.WVALID}); end
        cpu_cs = 1'b0; cpu_oe = 1'b1;
        #1;
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL nocs_stall got %b want 0", cpu_stall); end
        cpu_oe = 1'b0;
        step();
    endtask

    task automatic test_zero_wait_read();
        run_txn(14'h0004, 1'b1, 4'hF, 32'h0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00);
        n_cmp++; if (addr_q !== 32'h10) begin n_bad++; $display("FAIL rd0_araddr got %h want 10", addr_q); end
        n_cmp++; if (stalls !== 3) begin n_bad++; $display("FAIL rd0_stalls got %0d want 3", stalls); end
        n_cmp++; if (done_do !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd0_do got %h want deadbeef", done_do); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL rd0_err got %0d want 0", errs); end
        n_cmp++; if (ar_n !== 1) begin n_bad++; $display("FAIL rd0_ar_cycles got %0d want 1", ar_n); end
        n_cmp++; if (aw_n + w_n !== 0) begin n_bad++; $display("FAIL rd0_write_activity got %0d want 0", aw_n + w_n); end
        n_cmp++; if (after_stall !== 1'b0) begin n_bad++; $display("FAIL rd0_after_stall got %b want 0", after_stall); end
    endtask

    task automatic test_byte_write();
        run_txn(14'h0010, 1'b0, 4'b1101, 32'h0000AB00, 0, 0, 2, 0, 0, 32'h0, 2'b00);
        n_cmp++; if (addr_q !== 32'h40) begin n_bad++; $display("FAIL wr_awaddr got %h want 40", addr_q); end
        n_cmp++; if (wstrb_q !== 4'b0010) begin n_bad++; $display("FAIL wr_wstrb got %b want 0010", wstrb_q); end
        n_cmp++; if (wdata_q !== 32'h0000AB00) begin n_bad++; $display("FAIL wr_wdata got %h want 0000ab00", wdata_q); end
        n_cmp++; if (aw_n !== 3) begin n_bad++; $display("FAIL wr_awvalid_cycles got %0d want 3", aw_n); end
        n_cmp++; if (w_n !== 1) begin n_bad++; $display("FAIL wr_wvalid_cycles got %0d want 1", w_n); end
        n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL wr_awaddr_stable got %b want 1", stable); end
        n_cmp++; if (stalls !== 5) begin n_bad++; $display("FAIL wr_stalls got %0d want 5", stalls); end
        n_cmp++; if (done_do !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_do_kept got %h want deadbeef", done_do); end
        n_cmp++; if (ar_n !== 0) begin n_bad++; $display("FAIL wr_ar_cycles got %0d want 0", ar_n); end
    endtask

    // ARREADY low for 5 ARVALID cycles, RVALID on the 4th R cycle: 1 + 6 + 4 stall cycles.
    task automatic test_wait_states();
        run_txn(14'h3FFF, 1'b1, 4'hF, 32'h0, 5, 3, 0, 0, 0, 32'hCAFEF00D, 2'b01);
        n_cmp++; if (addr_q !== 32'hFFFC) begin n_bad++; $display("FAIL ws_araddr got %h want fffc", addr_q); end
        n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL ws_araddr_stable got %b want 1", stable); end
        n_cmp++; if (ar_n !== 6) begin n_bad++; $display("FAIL ws_ar_cycles got %0d want 6", ar_n); end
        n_cmp++; if (stalls !== 11) begin n_bad++; $display("FAIL ws_stalls got %0d want 11", stalls); end
        n_cmp++; if (done_do !== 32'hCAFEF00D) begin n_bad++; $display("FAIL ws_do got %h want cafef00d", done_do); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL ws_err got %0d want 0", errs); end
    endtask

    task automatic test_error_resp();
        // write wins over a simultaneous oe
        run_txn(14'h0001, 1'b1, 4'h0, 32'h11223344, 0, 0, 0, 0, 0, 32'h0, 2'b10);
        n_cmp++; if (ar_n !== 0 || aw_n !== 1) begin n_bad++; $display("FAIL werr_precedence got ar=%0d aw=%0d want ar=0 aw=1", ar_n, aw_n); end
        n_cmp++; if (wstrb_q !== 4'hF) begin n_bad++; $display("FAIL werr_wstrb got %b want 1111", wstrb_q); end
        n_cmp++; if (addr_q !== 32'h4) begin n_bad++; $display("FAIL werr_awaddr got %h want 4", addr_q); end
        n_cmp++; if (stalls !== 3) begin n_bad++; $display("FAIL werr_stalls got %0d want 3", stalls); end
        n_cmp++; if (done_err !== 1'b1 || errs !== 1) begin n_bad++; $display("FAIL werr_pulse got done=%b n=%0d want done=1 n=1", done_err, errs); end
        n_cmp++; if (after_err !== 1'b0) begin n_bad++; $display("FAIL werr_after got %b want 0", after_err); end
        run_txn(14'h0002, 1'b1, 4'hF, 32'h0, 0, 0, 0, 0, 0, 32'h12345678, 2'b11);
        n_cmp++; if (done_err !== 1'b1 || errs !== 1) begin n_bad++; $display("FAIL rerr_pulse got done=%b n=%0d want done=1 n=1", done_err, errs); end
        n_cmp++; if (done_do !== 32'h12345678) begin n_bad++; $display("FAIL rerr_do got %h want 12345678", done_do); end
        n_cmp++; if (after_err !== 1'b0) begin n_bad++; $display("FAIL rerr_after got %b want 0", after_err); end
    endtask

    task automatic test_reset_mid_read();
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_web = 4'hF; cpu_addr = 14'h0005;
        axi.ARREADY = 1'b1;
        step(); step();
        axi.ARREADY = 1'b0;
        #1;
        n_cmp++; if (axi.RREADY !== 1'b1) begin n_bad++; $display("FAIL mid_in_r got rready=%b want 1", axi.RREADY); end
        rst = 1'b1; cpu_cs = 1'b0; cpu_oe = 1'b0;
        step();
        n_cmp++; if (axi.ARVALID !== 1'b0 || axi.RREADY !== 1'b0) begin n_bad++; $display("FAIL mid_valids got ar=%b r=%b want 0 0", axi.ARVALID, axi.RREADY); end
        n_cmp++; if (cpu_do !== 32'h0) begin n_bad++; $display("FAIL mid_do got %h want 0", cpu_do); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL mid_stall got %b want 0", cpu_stall); end
        rst = 1'b0;
        step();
    endtask

    initial begin
        axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = '0; axi.RRESP = '0; axi.RID = '0; axi.RLAST = 1'b1;
        axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = '0; axi.BID = '0;
        test_reset();
        test_fields();
        test_no_request();
        test_zero_wait_read();
        test_byte_write();
        test_wait_states();
        test_error_resp();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
